// File: rtl/spike_collector.sv
// Spike collector: gathers spike/done packets from the partial-sum adders into a bitmap,
// then streams recorded spike addresses in raster order once every adder closes the timestep.
module spike_collector #(
   parameter int unsigned WIDTH         = 64,
   parameter int unsigned NUM_ADDERS    = 5,
   parameter int unsigned MAP_DIM       = 21,
   parameter int unsigned NUM_TIMESTEPS = 10,
   parameter logic [3:0]  MEM_ADDR      = 4'b0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [9:0]       out_spike_addr,
   output logic [7:0]       out_timestep,
   output logic             ts_done,
   output logic             all_done,
   output logic [9:0]       spike_count,
   output logic [7:0]       err_count
);

   localparam int unsigned CELLS  = MAP_DIM * MAP_DIM;
   localparam int unsigned IDX_W  = $clog2(CELLS);
   localparam int unsigned DCNT_W = $clog2(NUM_ADDERS + 1);

   localparam logic [1:0] S_COLLECT  = 2'd0;
   localparam logic [1:0] S_DRAIN    = 2'd1;
   localparam logic [1:0] S_CLOSE    = 2'd2;
   localparam logic [1:0] S_FINISHED = 2'd3;

   localparam logic [9:0] DONE_PAYLOAD = 10'h3FF;
   localparam logic [1:0] TYPE_SPIKE   = 2'b11;

   logic [3:0] pkt_dst;
   logic [1:0] pkt_type;
   logic [9:0] pkt_payload;
   logic [4:0] pkt_x;
   logic [4:0] pkt_y;
   logic       unused_pkt_bits;

   assign pkt_dst         = in_data[59:56];
   assign pkt_type        = in_data[55:54];
   assign pkt_payload     = in_data[9:0];
   assign pkt_x           = in_data[9:5];
   assign pkt_y           = in_data[4:0];
   assign unused_pkt_bits = ^{in_data[63:60], in_data[53:10]};

   logic [1:0]        state_q, state_d;
   logic [CELLS-1:0]  map_q, map_d;
   logic [DCNT_W-1:0] done_cnt_q, done_cnt_d;
   logic [9:0]        spike_count_q, spike_count_d;
   logic [7:0]        err_count_q, err_count_d;
   logic [7:0]        timestep_q, timestep_d;
   logic [4:0]        x_q, x_d;
   logic [4:0]        y_q, y_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [9:0]        out_addr_q, out_addr_d;
   logic              ts_done_q, ts_done_d;
   logic              all_done_q, all_done_d;

   logic [IDX_W-1:0]  in_idx;
   logic [IDX_W-1:0]  scan_idx;
   logic              in_range;
   logic              scan_last;
   logic              advance;
   logic              err_bump;

   // Next-state, bitmap and counter update.
   always_comb begin
      state_d       = state_q;
      map_d         = map_q;
      done_cnt_d    = done_cnt_q;
      spike_count_d = spike_count_q;
      err_count_d   = err_count_q;
      timestep_d    = timestep_q;
      x_d           = x_q;
      y_d           = y_q;
      out_valid_d   = out_valid_q;
      out_addr_d    = out_addr_q;
      ts_done_d     = 1'b0;
      advance       = 1'b0;
      err_bump      = 1'b0;

      in_idx    = IDX_W'(32'(pkt_x) * MAP_DIM + 32'(pkt_y));
      scan_idx  = IDX_W'(32'(x_q) * MAP_DIM + 32'(y_q));
      in_range  = (32'(pkt_x) < MAP_DIM) && (32'(pkt_y) < MAP_DIM);
      scan_last = (32'(x_q) == MAP_DIM - 1) && (32'(y_q) == MAP_DIM - 1);

      case (state_q)
         S_COLLECT: begin
            if (in_valid && in_ready_q) begin
               if ((pkt_dst != MEM_ADDR) || (pkt_type != TYPE_SPIKE)) begin
                  err_bump = 1'b1;
               end else if (pkt_payload == DONE_PAYLOAD) begin
                  done_cnt_d = done_cnt_q + DCNT_W'(1);
                  if (32'(done_cnt_q) + 1 == NUM_ADDERS) begin
                     state_d = S_DRAIN;
                  end
               end else if (in_range) begin
                  if (!map_q[in_idx]) begin
                     map_d[in_idx] = 1'b1;
                     spike_count_d = spike_count_q + 10'd1;
                  end
               end else begin
                  err_bump = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            // A set cell is presented first, then cleared and skipped on handshake.
            if (out_valid_q) begin
               if (out_ready) begin
                  map_d[scan_idx] = 1'b0;
                  out_valid_d     = 1'b0;
                  advance         = 1'b1;
               end
            end else if (map_q[scan_idx]) begin
               out_valid_d = 1'b1;
               out_addr_d  = {x_q, y_q};
            end else begin
               advance = 1'b1;
            end
            if (advance) begin
               if (scan_last) begin
                  x_d       = 5'd0;
                  y_d       = 5'd0;
                  state_d   = S_CLOSE;
                  ts_done_d = 1'b1;
               end else if (32'(y_q) == MAP_DIM - 1) begin
                  y_d = 5'd0;
                  x_d = x_q + 5'd1;
               end else begin
                  y_d = y_q + 5'd1;
               end
            end
         end
         S_CLOSE: begin
            done_cnt_d    = '0;
            spike_count_d = 10'd0;
            timestep_d    = timestep_q + 8'd1;
            if (32'(timestep_q) + 1 == NUM_TIMESTEPS) begin
               state_d = S_FINISHED;
            end else begin
               state_d = S_COLLECT;
            end
         end
         S_FINISHED: begin
            state_d = S_FINISHED;
         end
         default: begin
            state_d = S_COLLECT;
         end
      endcase

      if (err_bump && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end

      in_ready_d = (state_d == S_COLLECT);
      all_done_d = all_done_q || (state_d == S_FINISHED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_COLLECT;
         map_q         <= '0;
         done_cnt_q    <= '0;
         spike_count_q <= 10'd0;
         err_count_q   <= 8'd0;
         timestep_q    <= 8'd0;
         x_q           <= 5'd0;
         y_q           <= 5'd0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_addr_q    <= 10'd0;
         ts_done_q     <= 1'b0;
         all_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         map_q         <= map_d;
         done_cnt_q    <= done_cnt_d;
         spike_count_q <= spike_count_d;
         err_count_q   <= err_count_d;
         timestep_q    <= timestep_d;
         x_q           <= x_d;
         y_q           <= y_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         out_addr_q    <= out_addr_d;
         ts_done_q     <= ts_done_d;
         all_done_q    <= all_done_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign out_spike_addr = out_addr_q;
   assign out_timestep   = timestep_q;
   assign ts_done        = ts_done_q;
   assign all_done       = all_done_q;
   assign spike_count    = spike_count_q;
   assign err_count      = err_count_q;

endmodule

// File: tb/tb_spike_collector.sv
// Directed bench for spike_collector: packet vectors from a table, plus drain, back-pressure,
// mid-drain reset, timestep exhaustion and error-counter saturation sequences.
module tb_spike_collector;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  out_spike_addr;
   logic [7:0]  out_timestep;
   logic        ts_done;
   logic        all_done;
   logic [9:0]  spike_count;
   logic [7:0]  err_count;

   spike_collector dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_spike_addr (out_spike_addr),
      .out_timestep   (out_timestep),
      .ts_done        (ts_done),
      .all_done       (all_done),
      .spike_count    (spike_count),
      .err_count      (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        exp_ready;
      logic [9:0]  exp_sc;
      logic [7:0]  exp_ec;
   } vec_t;

   localparam logic [63:0] DONE = 64'hA0C00000000003FF;

   vec_t        vecs[$];
   logic [17:0] hs_q[$];
   int          total = 0;
   int          bad   = 0;
   int          ts_cnt = 0;
   bit          seen_valid = 1'b0;

   // Record every accepted spike as {timestep, addr}.
   always @(posedge clk) begin
      if (!reset && out_valid && out_ready) hs_q.push_back({out_timestep, out_spike_addr});
   end

   always @(negedge clk) begin
      if (ts_done) ts_cnt++;
      if (out_valid) seen_valid = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [63:0] d, input logic r, input logic [9:0] sc,
                               input logic [7:0] ec);
      vec_t v;
      v.data = d; v.exp_ready = r; v.exp_sc = sc; v.exp_ec = ec;
      return v;
   endfunction

   task automatic add_dones(input logic [9:0] sc, input logic [7:0] ec);
      for (int i = 0; i < 4; i++) vecs.push_back(mk(DONE, 1'b1, sc, ec));
      vecs.push_back(mk(DONE, 1'b0, sc, ec));
   endtask

   task automatic run_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         in_valid = 1'b1;
         in_data  = vecs[i].data;
         step();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         chk($sformatf("vec%0d_spike_count", i), 32'(spike_count), 32'(vecs[i].exp_sc));
         chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_ec));
      end
   endtask

   task automatic wait_ts(input int limit, output int n);
      n = 0;
      while (!ts_done && n < limit) begin
         step();
         n++;
      end
      if (!ts_done) begin
         total++;
         bad++;
         $display("FAIL ts_done_timeout: got 0 expected 1 within %0d cycles", limit);
      end
   endtask

   task automatic wait_valid(input int limit);
      int n;
      n = 0;
      while (!out_valid && n < limit) begin
         step();
         n++;
      end
      if (!out_valid) begin
         total++;
         bad++;
         $display("FAIL out_valid_timeout: got 0 expected 1 within %0d cycles", limit);
      end
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 64'd0;
      out_ready = 1'b1;

      // 0..5: single spike (3,4) then five dones
      vecs.push_back(mk(64'hA0C0000000000064, 1'b1, 10'd1, 8'd0));
      add_dones(10'd1, 8'd0);
      // 6..13: (20,20), (0,1), duplicate (0,1)
      vecs.push_back(mk(64'hA0C0000000000294, 1'b1, 10'd1, 8'd0));
      vecs.push_back(mk(64'hA0C0000000000001, 1'b1, 10'd2, 8'd0));
      vecs.push_back(mk(64'hA0C0000000000001, 1'b1, 10'd2, 8'd0));
      add_dones(10'd2, 8'd0);
      // 14..21: wrong dst, wrong type, x out of range
      vecs.push_back(mk(64'hA1C0000000000064, 1'b1, 10'd0, 8'd1));
      vecs.push_back(mk(64'hA080000000000064, 1'b1, 10'd0, 8'd2));
      vecs.push_back(mk(64'hA0C00000000002A0, 1'b1, 10'd0, 8'd3));
      add_dones(10'd0, 8'd3);
      // 22..28: (2,5), (2,6) for back-pressure
      vecs.push_back(mk(64'hA0C0000000000045, 1'b1, 10'd1, 8'd3));
      vecs.push_back(mk(64'hA0C0000000000046, 1'b1, 10'd2, 8'd3));
      add_dones(10'd2, 8'd3);
      // 29..33: empty timestep after a fresh reset
      add_dones(10'd0, 8'd0);

      // Reset values
      repeat (3) step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ts_done", 32'(ts_done), 32'd0);
      chk("rst_all_done", 32'(all_done), 32'd0);
      chk("rst_spike_count", 32'(spike_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Timestep 0: one spike
      hs_q.delete();
      ts_cnt = 0;
      run_vecs(0, 5);
      wait_ts(1000, n);
      chk("t0_hs_count", 32'(hs_q.size()), 32'd1);
      if (hs_q.size() > 0) chk("t0_hs0", 32'(hs_q[0]), 32'({8'd0, 10'h064}));
      step();
      chk("t0_ts_pulses", 32'(ts_cnt), 32'd1);
      chk("t0_ready_back", 32'(in_ready), 32'd1);
      chk("t0_sc_cleared", 32'(spike_count), 32'd0);

      // Timestep 1: raster order and duplicate
      hs_q.delete();
      run_vecs(6, 13);
      wait_ts(1000, n);
      step();
      chk("t1_hs_count", 32'(hs_q.size()), 32'd2);
      if (hs_q.size() > 1) begin
         chk("t1_hs0", 32'(hs_q[0]), 32'({8'd1, 10'h001}));
         chk("t1_hs1", 32'(hs_q[1]), 32'({8'd1, 10'h294}));
      end

      // Timestep 2: drops only, empty drain length
      hs_q.delete();
      seen_valid = 1'b0;
      run_vecs(14, 21);
      wait_ts(1000, n);
      chk("t2_drain_cycles", 32'(n), 32'd441);
      step();
      chk("t2_no_valid", 32'(seen_valid), 32'd0);
      chk("t2_hs_count", 32'(hs_q.size()), 32'd0);

      // Timestep 3: back-pressure then reset mid-drain
      hs_q.delete();
      out_ready = 1'b0;
      run_vecs(22, 28);
      wait_valid(1000);
      chk("bp_addr0", 32'(out_spike_addr), 32'h045);
      chk("bp_ts", 32'(out_timestep), 32'd3);
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp_hold%0d_addr", i), 32'(out_spike_addr), 32'h045);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      wait_valid(1000);
      chk("bp_addr1", 32'(out_spike_addr), 32'h046);
      reset = 1'b1;
      step();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_err_count", 32'(err_count), 32'd0);
      chk("mid_rst_spike_count", 32'(spike_count), 32'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      chk("mid_rst_ready_back", 32'(in_ready), 32'd1);
      chk("bp_hs_count", 32'(hs_q.size()), 32'd1);
      if (hs_q.size() > 0) chk("bp_hs0", 32'(hs_q[0]), 32'({8'd3, 10'h045}));

      // Ten empty timesteps from the fresh reset
      hs_q.delete();
      seen_valid = 1'b0;
      ts_cnt = 0;
      for (int t = 0; t < 10; t++) begin
         run_vecs(29, 33);
         wait_ts(1000, n);
         step();
         if (t == 8) chk("ts8_all_done_low", 32'(all_done), 32'd0);
      end
      chk("fin_ts_pulses", 32'(ts_cnt), 32'd10);
      chk("fin_no_valid", 32'(seen_valid), 32'd0);
      chk("fin_all_done", 32'(all_done), 32'd1);
      chk("fin_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_data  = 64'hA1C0000000000064;
      repeat (3) step();
      in_valid = 1'b0;
      chk("fin_ignore_err", 32'(err_count), 32'd0);
      chk("fin_hold_all_done", 32'(all_done), 32'd1);
      chk("fin_hold_in_ready", 32'(in_ready), 32'd0);

      // err_count saturation
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("sat_all_done_clear", 32'(all_done), 32'd0);
      in_valid = 1'b1;
      in_data  = 64'hA1C0000000000064;
      repeat (254) step();
      chk("sat_err_254", 32'(err_count), 32'd254);
      repeat (4) step();
      in_valid = 1'b0;
      chk("sat_err_255", 32'(err_count), 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
